// File: rtl/store_buffer_pkg.sv
// Shared types and sizing for the store buffer.
// The optional forwarding search is enabled by defining STORE_FORWARD_EN.
package store_buffer_pkg;

    localparam int FIFO_DEPTH = 8;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int ID_W       = $clog2(FIFO_DEPTH);

    localparam logic [2:0] FUNCT3_SW = 3'b010;

    typedef enum logic [1:0] {SB_FREE, SB_ALLOC, SB_READY, SB_COMMIT} sb_state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic                  valid;
        logic [2:0]            funct3;
        sb_state_t             state;
    } sb_entry_t;

    // Pointer with wrap bit above the entry index.
    typedef logic [ID_W:0] sb_ptr_t;

endpackage

// File: rtl/store_buffer_if.sv
// Bundle of dispatch, execute, commit, memory-write and forwarding signals.
// The store buffer takes the slave side; the surrounding pipeline the master side.
interface store_buffer_if;
    import store_buffer_pkg::*;

    logic                  alloc_valid;
    logic                  alloc_ready;
    logic [ID_W-1:0]       alloc_store_id;

    logic                  exec_valid;
    logic [ID_W-1:0]       exec_store_id;
    logic [2:0]            exec_funct3;
    logic [ADDR_WIDTH-1:0] exec_addr;
    logic [DATA_WIDTH-1:0] exec_data;

    logic                  commit_valid;
    logic [ID_W-1:0]       commit_store_id;
    logic                  flush;

    logic                  mem_wr_valid;
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic [DATA_WIDTH-1:0] mem_wr_data;
    logic [2:0]            mem_wr_funct3;
    logic                  mem_wr_ready;

    logic                  ld_valid;
    logic [ADDR_WIDTH-1:0] ld_addr;
    logic [ID_W:0]         ld_store_tail;
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic                  fwd_stall;

    logic                  empty;

    modport slave (
        input  alloc_valid, exec_valid, exec_store_id, exec_funct3, exec_addr, exec_data,
               commit_valid, commit_store_id, flush, mem_wr_ready,
               ld_valid, ld_addr, ld_store_tail,
        output alloc_ready, alloc_store_id, mem_wr_valid, mem_wr_addr, mem_wr_data,
               mem_wr_funct3, fwd_hit, fwd_data, fwd_stall, empty
    );

    modport master (
        output alloc_valid, exec_valid, exec_store_id, exec_funct3, exec_addr, exec_data,
               commit_valid, commit_store_id, flush, mem_wr_ready,
               ld_valid, ld_addr, ld_store_tail,
        input  alloc_ready, alloc_store_id, mem_wr_valid, mem_wr_addr, mem_wr_data,
               mem_wr_funct3, fwd_hit, fwd_data, fwd_stall, empty
    );

endinterface

// File: rtl/store_buffer_forward_unit.sv
// Combinational store-to-load forwarding: youngest word-address match among
// entries older than the load's tail snapshot, with stall on unknown or partial stores.
module store_forward_unit
    import store_buffer_pkg::*;
(
    input  sb_entry_t             i_entries [FIFO_DEPTH],
    input  sb_ptr_t               i_head,
    input  logic                  i_ld_valid,
    input  logic [ADDR_WIDTH-1:0] i_ld_addr,
    input  sb_ptr_t               i_ld_store_tail,
    output logic                  o_fwd_hit,
    output logic [DATA_WIDTH-1:0] o_fwd_data,
    output logic                  o_fwd_stall
);

    sb_ptr_t               w_span;
    sb_entry_t             w_e;
    logic                  w_match;
    logic                  w_full;
    logic                  w_alloc_seen;
    logic [ADDR_WIDTH-1:0] w_y_addr;
    logic [DATA_WIDTH-1:0] w_y_data;
    logic [2:0]            w_y_funct3;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves a latch behind.
        w_span       = i_ld_store_tail - i_head;
        w_e          = '0;
        w_match      = 1'b0;
        w_alloc_seen = 1'b0;
        w_y_addr     = '0;
        w_y_data     = '0;
        w_y_funct3   = '0;
        // Walk oldest to youngest so the last hit is the youngest match.
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            w_e = i_entries[i_head[ID_W-1:0] + ID_W'(k)];
            if (sb_ptr_t'(k) < w_span && w_e.valid) begin
                if (w_e.state == SB_ALLOC) begin
                    w_alloc_seen = 1'b1;
                end else if (w_e.addr[ADDR_WIDTH-1:2] == i_ld_addr[ADDR_WIDTH-1:2]) begin
                    w_match    = 1'b1;
                    w_y_addr   = w_e.addr;
                    w_y_data   = w_e.data;
                    w_y_funct3 = w_e.funct3;
                end
            end
        end
        w_full      = w_match && w_y_funct3 == FUNCT3_SW && w_y_addr == i_ld_addr;
        o_fwd_stall = i_ld_valid && (w_alloc_seen || (w_match && !w_full));
        o_fwd_hit   = i_ld_valid && w_full && !w_alloc_seen;
        o_fwd_data  = o_fwd_hit ? w_y_data : '0;
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer: allocate at dispatch, fill at execute, commit at retire,
// drain committed head to memory. Define STORE_FORWARD_EN for exact forwarding.
module store_buffer
    import store_buffer_pkg::*;
(
    input logic           clk,
    input logic           rst,
    store_buffer_if.slave sb
);

    sb_entry_t r_entries [FIFO_DEPTH];
    sb_state_t w_state_nxt [FIFO_DEPTH];
    sb_ptr_t   r_head, r_cmt, r_tail;
    sb_ptr_t   w_count;
    logic      w_full, w_alloc, w_exec, w_drain, w_mem_valid;

    assign w_count     = r_tail - r_head;
    assign w_full      = w_count == sb_ptr_t'(FIFO_DEPTH);
    assign w_mem_valid = r_entries[r_head[ID_W-1:0]].state == SB_COMMIT;
    assign w_alloc     = sb.alloc_valid && !w_full && !sb.flush;
    assign w_exec      = sb.exec_valid && !sb.flush && r_entries[sb.exec_store_id].state == SB_ALLOC;
    assign w_drain     = w_mem_valid && sb.mem_wr_ready;

    assign sb.alloc_ready    = !w_full;
    assign sb.alloc_store_id = r_tail[ID_W-1:0];
    assign sb.empty          = r_head == r_tail;
    assign sb.mem_wr_valid   = w_mem_valid;
    assign sb.mem_wr_addr    = r_entries[r_head[ID_W-1:0]].addr;
    assign sb.mem_wr_data    = r_entries[r_head[ID_W-1:0]].data;
    assign sb.mem_wr_funct3  = r_entries[r_head[ID_W-1:0]].funct3;

    // Commit is applied before flush, so the retiring entry survives as COMMIT.
    always_comb begin
        for (int i = 0; i < FIFO_DEPTH; i++) w_state_nxt[i] = r_entries[i].state;
        if (w_exec)          w_state_nxt[sb.exec_store_id]    = SB_READY;
        if (sb.commit_valid) w_state_nxt[r_cmt[ID_W-1:0]]     = SB_COMMIT;
        if (w_drain)         w_state_nxt[r_head[ID_W-1:0]]    = SB_FREE;
        if (sb.flush) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (w_state_nxt[i] == SB_ALLOC || w_state_nxt[i] == SB_READY)
                    w_state_nxt[i] = SB_FREE;
            end
        end
        if (w_alloc)         w_state_nxt[r_tail[ID_W-1:0]]    = SB_ALLOC;
    end

    // NOTE: the entry array is reset as a whole; it is small and the state field must start FREE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head <= '0;
            r_cmt  <= '0;
            r_tail <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_entries[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            r_head <= r_head + sb_ptr_t'(w_drain);
            r_cmt  <= r_cmt + sb_ptr_t'(sb.commit_valid);
            r_tail <= sb.flush ? r_cmt + sb_ptr_t'(sb.commit_valid) : r_tail + sb_ptr_t'(w_alloc);
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_entries[i].state <= w_state_nxt[i];
                r_entries[i].valid <= w_state_nxt[i] != SB_FREE;
            end
            if (w_exec) begin
                r_entries[sb.exec_store_id].addr   <= sb.exec_addr;
                r_entries[sb.exec_store_id].data   <= sb.exec_data;
                r_entries[sb.exec_store_id].funct3 <= sb.exec_funct3;
            end
            if (sb.commit_valid)
                assert (sb.commit_store_id == r_cmt[ID_W-1:0] &&
                        r_entries[sb.commit_store_id].state == SB_READY);
        end
    end

`ifdef STORE_FORWARD_EN
    store_forward_unit u_fwd (
        .i_entries       (r_entries),
        .i_head          (r_head),
        .i_ld_valid      (sb.ld_valid),
        .i_ld_addr       (sb.ld_addr),
        .i_ld_store_tail (sb.ld_store_tail),
        .o_fwd_hit       (sb.fwd_hit),
        .o_fwd_data      (sb.fwd_data),
        .o_fwd_stall     (sb.fwd_stall)
    );
`else
    // Without the search, any occupied older entry conservatively stalls the load.
    sb_ptr_t w_span;
    logic    w_occupied_older;
    logic    w_unused_ld_addr;

    always_comb begin
        w_span           = sb.ld_store_tail - r_head;
        w_occupied_older = 1'b0;
        for (int k = 0; k < FIFO_DEPTH; k++) begin
            if (sb_ptr_t'(k) < w_span && r_entries[r_head[ID_W-1:0] + ID_W'(k)].valid)
                w_occupied_older = 1'b1;
        end
    end

    assign sb.fwd_hit        = 1'b0;
    assign sb.fwd_data       = '0;
    assign sb.fwd_stall      = sb.ld_valid && w_occupied_older;
    assign w_unused_ld_addr  = ^sb.ld_addr;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed sequences plus a forwarding vector table.
module tb_store_buffer;
    import store_buffer_pkg::*;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    store_buffer_if sb_if ();

    store_buffer dut (
        .clk (clk),
        .rst (rst),
        .sb  (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic                  ld_valid;
        logic [ADDR_WIDTH-1:0] ld_addr;
        logic [ID_W:0]         tail;
        logic                  hit;
        logic [DATA_WIDTH-1:0] data;
        logic                  stall_on;
        logic                  stall_off;
    } fwd_vec_t;

    fwd_vec_t vecs [9];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        sb_if.alloc_valid     = 1'b0;
        sb_if.exec_valid      = 1'b0;
        sb_if.exec_store_id   = '0;
        sb_if.exec_funct3     = '0;
        sb_if.exec_addr       = '0;
        sb_if.exec_data       = '0;
        sb_if.commit_valid    = 1'b0;
        sb_if.commit_store_id = '0;
        sb_if.flush           = 1'b0;
        sb_if.mem_wr_ready    = 1'b0;
        sb_if.ld_valid        = 1'b0;
        sb_if.ld_addr         = '0;
        sb_if.ld_store_tail   = '0;
    endtask

    task automatic do_alloc(input logic [ID_W-1:0] exp_id);
        sb_if.alloc_valid = 1'b1;
        #1;
        check("alloc_ready", sb_if.alloc_ready, 1'b1);
        check("alloc_id", sb_if.alloc_store_id, exp_id);
        tick();
        sb_if.alloc_valid = 1'b0;
    endtask

    task automatic do_exec(input logic [ID_W-1:0] id, input logic [31:0] addr,
                           input logic [31:0] data, input logic [2:0] f3);
        sb_if.exec_valid    = 1'b1;
        sb_if.exec_store_id = id;
        sb_if.exec_addr     = addr;
        sb_if.exec_data     = data;
        sb_if.exec_funct3   = f3;
        tick();
        sb_if.exec_valid = 1'b0;
    endtask

    task automatic do_commit(input logic [ID_W-1:0] id);
        sb_if.commit_valid    = 1'b1;
        sb_if.commit_store_id = id;
        tick();
        sb_if.commit_valid = 1'b0;
    endtask

    function automatic logic [ID_W-1:0] wrap_id(input int s);
        return ID_W'(11 + s);
    endfunction

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        idle();

        // Fields: ld_valid, ld_addr, tail snapshot, hit, data, stall (forwarding), stall (conservative)
        vecs[0] = '{1'b1, 32'h200, 4'hD, 1'b1, 32'h22, 1'b0, 1'b1};
        vecs[1] = '{1'b1, 32'h200, 4'hC, 1'b1, 32'h11, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 32'h200, 4'hE, 1'b0, 32'h0,  1'b1, 1'b1};
        vecs[3] = '{1'b1, 32'h200, 4'hF, 1'b0, 32'h0,  1'b1, 1'b1};
        vecs[4] = '{1'b1, 32'h300, 4'hD, 1'b0, 32'h0,  1'b0, 1'b1};
        vecs[5] = '{1'b1, 32'h200, 4'hB, 1'b0, 32'h0,  1'b0, 1'b0};
        vecs[6] = '{1'b0, 32'h200, 4'hD, 1'b0, 32'h0,  1'b0, 1'b0};
        vecs[7] = '{1'b1, 32'h202, 4'hD, 1'b0, 32'h0,  1'b1, 1'b1};
        vecs[8] = '{1'b1, 32'h300, 4'hF, 1'b0, 32'h0,  1'b1, 1'b1};

        tick();
        check("rst_alloc_ready", sb_if.alloc_ready, 1'b1);
        check("rst_alloc_id", sb_if.alloc_store_id, 0);
        check("rst_mem_valid", sb_if.mem_wr_valid, 1'b0);
        check("rst_empty", sb_if.empty, 1'b1);
        check("rst_fwd_hit", sb_if.fwd_hit, 1'b0);
        check("rst_fwd_data", sb_if.fwd_data, 0);
        check("rst_fwd_stall", sb_if.fwd_stall, 1'b0);
        rst = 1'b0;
        tick();

        // Fill and drain
        for (int i = 0; i < 8; i++) do_alloc(ID_W'(i));
        check("full_alloc_ready", sb_if.alloc_ready, 1'b0);
        check("full_not_empty", sb_if.empty, 1'b0);
        for (int i = 0; i < 8; i++) do_exec(ID_W'(i), 32'h1000 + 4*i, 32'hA0 + i, FUNCT3_SW);
        do_commit(0);
        check("commit_latency", sb_if.mem_wr_valid, 1'b1);
        for (int i = 1; i < 8; i++) do_commit(ID_W'(i));
        sb_if.mem_wr_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sb_if.alloc_valid = (i == 0);
            #1;
            if (i == 0) check("full_drain_alloc_ready", sb_if.alloc_ready, 1'b0);
            check("drain_valid", sb_if.mem_wr_valid, 1'b1);
            check("drain_addr", sb_if.mem_wr_addr, 32'h1000 + 4*i);
            check("drain_data", sb_if.mem_wr_data, 32'hA0 + i);
            tick();
            sb_if.alloc_valid = 1'b0;
            if (i == 0) check("no_bypass_alloc", sb_if.alloc_store_id, 0);
        end
        sb_if.mem_wr_ready = 1'b0;
        check("drained_empty", sb_if.empty, 1'b1);
        check("drained_valid", sb_if.mem_wr_valid, 1'b0);

        // Flush discards uncommitted entries
        for (int i = 0; i < 4; i++) do_alloc(ID_W'(i));
        for (int i = 0; i < 4; i++) do_exec(ID_W'(i), 32'h2000 + 4*i, 32'hB0 + i, FUNCT3_SW);
        do_commit(0);
        do_commit(1);
        sb_if.flush = 1'b1;
        tick();
        sb_if.flush = 1'b0;
        check("flush_tail", sb_if.alloc_store_id, 2);
        sb_if.mem_wr_ready = 1'b1;
        #1;
        check("flush_drain0", sb_if.mem_wr_data, 32'hB0);
        tick();
        check("flush_drain1", sb_if.mem_wr_data, 32'hB1);
        tick();
        check("flush_no_more", sb_if.mem_wr_valid, 1'b0);
        check("flush_empty", sb_if.empty, 1'b1);
        sb_if.mem_wr_ready = 1'b0;

        // Backpressure holds the head store stable
        do_alloc(2);
        do_exec(2, 32'h100, 32'hDEADBEEF, FUNCT3_SW);
        do_commit(2);
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", sb_if.mem_wr_valid, 1'b1);
            check("bp_addr", sb_if.mem_wr_addr, 32'h100);
            check("bp_data", sb_if.mem_wr_data, 32'hDEADBEEF);
            check("bp_funct3", sb_if.mem_wr_funct3, FUNCT3_SW);
            tick();
        end
        sb_if.mem_wr_ready = 1'b1;
        #1;
        check("bp_release_valid", sb_if.mem_wr_valid, 1'b1);
        tick();
        sb_if.mem_wr_ready = 1'b0;
        check("bp_done_empty", sb_if.empty, 1'b1);

        // Forwarding table: entries 3,4 SW 0x200; 5 SB 0x201; 6 left ALLOC
        do_alloc(3);
        do_exec(3, 32'h200, 32'h11, FUNCT3_SW);
        do_alloc(4);
        do_exec(4, 32'h200, 32'h22, FUNCT3_SW);
        do_alloc(5);
        do_exec(5, 32'h201, 32'h33, 3'b000);
        do_alloc(6);
        for (int v = 0; v < 9; v++) begin
            sb_if.ld_valid      = vecs[v].ld_valid;
            sb_if.ld_addr       = vecs[v].ld_addr;
            sb_if.ld_store_tail = vecs[v].tail;
            #1;
`ifdef STORE_FORWARD_EN
            check($sformatf("fwd_hit[%0d]", v), sb_if.fwd_hit, vecs[v].hit);
            check($sformatf("fwd_data[%0d]", v), sb_if.fwd_data, vecs[v].data);
            check($sformatf("fwd_stall[%0d]", v), sb_if.fwd_stall, vecs[v].stall_on);
`else
            check($sformatf("fwd_hit[%0d]", v), sb_if.fwd_hit, 1'b0);
            check($sformatf("fwd_data[%0d]", v), sb_if.fwd_data, 0);
            check($sformatf("fwd_stall[%0d]", v), sb_if.fwd_stall, vecs[v].stall_off);
`endif
        end
        sb_if.ld_valid = 1'b0;
        sb_if.flush = 1'b1;
        tick();
        sb_if.flush = 1'b0;
        check("fwd_flush_empty", sb_if.empty, 1'b1);
        check("fwd_flush_tail", sb_if.alloc_store_id, 3);

        // Wrap: alloc, exec, commit and drain all in the same cycle
        for (int t = 0; t < 23; t++) begin
            sb_if.alloc_valid     = (t < 20);
            sb_if.exec_valid      = (t >= 1 && t <= 20);
            sb_if.exec_store_id   = wrap_id(t - 1);
            sb_if.exec_addr       = 32'h6000 + 4*(t - 1);
            sb_if.exec_data       = 32'h5000 + (t - 1);
            sb_if.exec_funct3     = FUNCT3_SW;
            sb_if.commit_valid    = (t >= 2 && t <= 21);
            sb_if.commit_store_id = wrap_id(t - 2);
            sb_if.mem_wr_ready    = 1'b1;
            #1;
            if (t < 20) begin
                check("wrap_alloc_ready", sb_if.alloc_ready, 1'b1);
                check("wrap_alloc_id", sb_if.alloc_store_id, wrap_id(t));
            end
            if (t >= 3) begin
                check("wrap_drain_valid", sb_if.mem_wr_valid, 1'b1);
                check("wrap_drain_data", sb_if.mem_wr_data, 32'h5000 + (t - 3));
            end else begin
                check("wrap_pre_valid", sb_if.mem_wr_valid, 1'b0);
            end
            tick();
        end
        idle();
        check("wrap_empty", sb_if.empty, 1'b1);

        // Commit and flush in the same cycle keep the committed store
        do_alloc(7);
        do_exec(7, 32'h700, 32'h7777, FUNCT3_SW);
        do_alloc(0);
        do_exec(0, 32'h704, 32'h8888, FUNCT3_SW);
        sb_if.commit_valid    = 1'b1;
        sb_if.commit_store_id = 7;
        sb_if.flush           = 1'b1;
        tick();
        idle();
        check("cf_tail", sb_if.alloc_store_id, 0);
        check("cf_valid", sb_if.mem_wr_valid, 1'b1);
        check("cf_data", sb_if.mem_wr_data, 32'h7777);
        sb_if.mem_wr_ready = 1'b1;
        tick();
        sb_if.mem_wr_ready = 1'b0;
        check("cf_empty", sb_if.empty, 1'b1);

        // Reset during drain
        do_alloc(0);
        do_exec(0, 32'h900, 32'h9999, FUNCT3_SW);
        do_commit(0);
        check("rd_valid_before", sb_if.mem_wr_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("rd_valid_async", sb_if.mem_wr_valid, 1'b0);
        check("rd_empty_async", sb_if.empty, 1'b1);
        check("rd_tail_async", sb_if.alloc_store_id, 0);
        tick();
        rst = 1'b0;
        tick();
        check("rd_empty_after", sb_if.empty, 1'b1);
        check("rd_ready_after", sb_if.alloc_ready, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
